// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader
//   Boot-time loader for the mips32 core's instruction/data memory. Takes a
//   byte stream framed as LEN_HI, LEN_LO, N*4 payload bytes (big-endian words),
//   CSUM (XOR of payload bytes). Each assembled word is written through a
//   single-cycle write port. cpu_run is raised only after the checksum matches.
//
// Ports
//   clk1, rst          clock, synchronous active-high reset
//   rx_valid/rx_data   byte stream in; rx_ready is the accept handshake
//   mem_we/addr/wdata  one-cycle memory write strobe, word address, word data
//   cpu_run            image verified, core released (sticky until rst)
//   busy               frame in progress (after LEN_HI, before DONE/ERR)
//   error              0 none, 1 length error, 2 checksum error (sticky)
//   words_written      words written in the current frame
module mips32_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic [1:0]        error,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0]     MAX_N = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         asm_q, asm_d;     // first three bytes of the current word
  logic [7:0]          csum_q, csum_d;
  logic [ADDR_W:0]     ww_q, ww_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                run_q, run_d;
  logic [1:0]          err_q, err_d;

  logic                acc;
  logic [15:0]         len_full;
  logic                len_ok;

  // Ready is purely a function of state so it never combinationally
  // depends on rx_valid.
  assign rx_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign busy     = (state_q == S_LEN_LO) || (state_q == S_DATA) ||
                    (state_q == S_CSUM);
  assign acc      = rx_valid && rx_ready;

  assign len_full = {len_hi_q, rx_data};
  assign len_ok   = (len_full != 16'd0) && ({1'b0, len_full} <= MAX_N);

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    bcnt_d   = bcnt_q;
    asm_d    = asm_q;
    csum_d   = csum_q;
    ww_d     = ww_q;
    we_d     = 1'b0;          // strobe lasts exactly one cycle
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    run_d    = run_q;
    err_d    = err_q;

    case (state_q)
      S_LEN_HI: if (acc) begin
        len_hi_d = rx_data;
        state_d  = S_LEN_LO;
      end
      S_LEN_LO: if (acc) begin
        if (len_ok) begin
          len_d   = len_full[ADDR_W:0];
          state_d = S_DATA;
        end else begin
          err_d   = 2'd1;
          state_d = S_ERR;
        end
      end
      S_DATA: if (acc) begin
        csum_d = csum_q ^ rx_data;
        bcnt_d = bcnt_q + 2'd1;
        asm_d  = {asm_q[15:0], rx_data};
        if (bcnt_q == 2'd3) begin
          // Write registers are separate from asm_q, so the next word can
          // start assembling while this one is on the write port.
          we_d    = 1'b1;
          addr_d  = ww_q[ADDR_W-1:0];
          wdata_d = {asm_q, rx_data};
          ww_d    = ww_q + ONE;
          if (ww_q == len_q - ONE) state_d = S_CSUM;
        end
      end
      S_CSUM: if (acc) begin
        if (rx_data == csum_q) begin
          run_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          err_d   = 2'd2;
          state_d = S_ERR;
        end
      end
      default: ;              // S_DONE / S_ERR hold until rst
    endcase
  end

  // Reset wins over acceptance and also cancels a write scheduled for the
  // following cycle (we_q cleared on the same edge).
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q  <= S_LEN_HI;
      len_hi_q <= '0;
      len_q    <= '0;
      bcnt_q   <= '0;
      asm_q    <= '0;
      csum_q   <= '0;
      ww_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      run_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      bcnt_q   <= bcnt_d;
      asm_q    <= asm_d;
      csum_q   <= csum_d;
      ww_q     <= ww_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      run_q    <= run_d;
      err_q    <= err_d;
    end
  end

  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign cpu_run       = run_q;
  assign error         = err_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
module tb_mips32_prog_loader;
  localparam int ADDR_W = 10;

  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready, mem_we, cpu_run, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        error;
  logic [ADDR_W:0]   words_written;

  int checks = 0;
  int errs   = 0;

  // write monitor (only this process writes these)
  int                wr_cnt = 0;
  int                dbl_we = 0;
  logic              prev_we = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [31:0]       last_data = '0;

  mips32_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk1(clk1), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .error(error),
    .words_written(words_written)
  );

  always #5 clk1 = ~clk1;

  always @(negedge clk1) begin
    if (mem_we) begin
      wr_cnt    = wr_cnt + 1;
      last_addr = mem_addr;
      last_data = mem_wdata;
      if (prev_we) dbl_we = dbl_we + 1;
    end
    prev_we = mem_we;
  end

  // present a byte for one cycle; returns #1 after the accepting edge
  task automatic drive(input logic [7:0] b);
    @(negedge clk1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk1);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk1);
      rx_valid = 1'b0;
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk1);
    #1;
    @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rx_ready !== 1'b1 || mem_we !== 1'b0 || cpu_run !== 1'b0 || busy !== 1'b0 ||
        mem_addr !== '0 || mem_wdata !== 32'h0 || error !== 2'd0 || words_written !== '0) begin
      errs++;
      $display("FAIL reset: rdy=%b we=%b run=%b busy=%b addr=%0d wd=%h err=%0d ww=%0d required 1 0 0 0 0 0 0 0",
               rx_ready, mem_we, cpu_run, busy, mem_addr, mem_wdata, error, words_written);
    end
  endtask

  task automatic test_nominal_and_lockout();
    int base, ww_hold;
    do_reset();
    base = wr_cnt;
    drive(8'h00);
    checks++;
    if (busy !== 1'b1) begin errs++; $display("FAIL busy_after_len_hi: got %b want 1", busy); end
    drive(8'h02);
    drive(8'h21); drive(8'h00); drive(8'h00); drive(8'h0A);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 0 || mem_wdata !== 32'h2100000A || words_written !== 1) begin
      errs++;
      $display("FAIL nom_word0: we=%b addr=%0d data=%h ww=%0d required 1 0 2100000a 1",
               mem_we, mem_addr, mem_wdata, words_written);
    end
    drive(8'hFC);
    checks++;
    if (mem_we !== 1'b0) begin errs++; $display("FAIL nom_we_pulse_len: got %b want 0", mem_we); end
    drive(8'h00); drive(8'h00); drive(8'h00);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 1 || mem_wdata !== 32'hFC000000 || words_written !== 2 || cpu_run !== 1'b0) begin
      errs++;
      $display("FAIL nom_word1: we=%b addr=%0d data=%h ww=%0d run=%b required 1 1 fc000000 2 0",
               mem_we, mem_addr, mem_wdata, words_written, cpu_run);
    end
    drive(8'hD7);
    checks++;
    if (cpu_run !== 1'b1 || error !== 2'd0 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      errs++;
      $display("FAIL nom_done: run=%b err=%0d busy=%b rdy=%b required 1 0 0 0", cpu_run, error, busy, rx_ready);
    end
    idle(1);
    checks++;
    if (wr_cnt - base !== 2) begin errs++; $display("FAIL nom_write_count: got %0d want 2", wr_cnt - base); end
    // post-done lockout
    base = wr_cnt;
    ww_hold = int'(words_written);
    for (int i = 0; i < 10; i++) drive(8'(8'hA0 + i));
    idle(1);
    checks++;
    if (rx_ready !== 1'b0 || wr_cnt != base || int'(words_written) != ww_hold || cpu_run !== 1'b1) begin
      errs++;
      $display("FAIL lockout: rdy=%b writes=%0d ww=%0d run=%b required 0 0 2 1",
               rx_ready, wr_cnt - base, words_written, cpu_run);
    end
  endtask

  task automatic test_csum_error();
    int base;
    do_reset();
    base = wr_cnt;
    drive(8'h00); drive(8'h02);
    drive(8'h21); drive(8'h00); drive(8'h00); drive(8'h0A);
    drive(8'hFC); drive(8'h00); drive(8'h00); drive(8'h00);
    drive(8'hD6);
    idle(1);
    checks++;
    if (error !== 2'd2 || cpu_run !== 1'b0 || rx_ready !== 1'b0 || wr_cnt - base !== 2 || words_written !== 2) begin
      errs++;
      $display("FAIL csum_err: err=%0d run=%b rdy=%b writes=%0d ww=%0d required 2 0 0 2 2",
               error, cpu_run, rx_ready, wr_cnt - base, words_written);
    end
  endtask

  task automatic test_len_error(input logic [7:0] hi, input logic [7:0] lo);
    int base;
    do_reset();
    base = wr_cnt;
    drive(hi);
    drive(lo);
    checks++;
    if (error !== 2'd1 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      errs++;
      $display("FAIL len_err_%02h%02h: err=%0d busy=%b rdy=%b required 1 0 0", hi, lo, error, busy, rx_ready);
    end
    for (int i = 0; i < 8; i++) drive(8'h55);
    idle(1);
    checks++;
    if (wr_cnt != base || error !== 2'd1 || cpu_run !== 1'b0) begin
      errs++;
      $display("FAIL len_err_nowrite_%02h%02h: writes=%0d err=%0d run=%b required 0 1 0",
               hi, lo, wr_cnt - base, error, cpu_run);
    end
  endtask

  task automatic test_len_max();
    int base;
    logic [7:0] cs, b;
    do_reset();
    base = wr_cnt;
    cs = 8'h00;
    drive(8'h04); drive(8'h00);
    checks++;
    if (error !== 2'd0 || busy !== 1'b1) begin
      errs++; $display("FAIL len_1024_accept: err=%0d busy=%b required 0 1", error, busy);
    end
    for (int k = 0; k < 1024; k++)
      for (int j = 0; j < 4; j++) begin
        b  = 8'((k * 3 + j * 7) & 8'hFF);
        cs = cs ^ b;
        drive(b);
      end
    drive(cs);
    idle(1);
    // last word k=1023: bytes (3069+7j)&ff -> fd, 04, 0b, 12
    checks++;
    if (wr_cnt - base !== 1024 || last_addr !== 10'd1023 || last_data !== 32'hFD040B12 ||
        words_written !== 11'd1024 || cpu_run !== 1'b1 || dbl_we !== 0) begin
      errs++;
      $display("FAIL len_1024: writes=%0d last_addr=%0d last_data=%h ww=%0d run=%b dbl=%0d required 1024 1023 fd040b12 1024 1 0",
               wr_cnt - base, last_addr, last_data, words_written, cpu_run, dbl_we);
    end
  endtask

  task automatic test_stall();
    int base;
    do_reset();
    base = wr_cnt;
    drive(8'h00); drive(8'h01);
    drive(8'hDE);
    idle(5);
    checks++;
    if (busy !== 1'b1 || words_written !== 0 || wr_cnt != base || error !== 2'd0) begin
      errs++;
      $display("FAIL stall_hold: busy=%b ww=%0d writes=%0d err=%0d required 1 0 0 0",
               busy, words_written, wr_cnt - base, error);
    end
    drive(8'hAD); drive(8'hBE); drive(8'hEF);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 0 || mem_wdata !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL stall_word: we=%b addr=%0d data=%h required 1 0 deadbeef", mem_we, mem_addr, mem_wdata);
    end
    drive(8'h22);
    idle(2);
    checks++;
    if (cpu_run !== 1'b1 || wr_cnt - base !== 1 || error !== 2'd0) begin
      errs++;
      $display("FAIL stall_done: run=%b writes=%0d err=%0d required 1 1 0", cpu_run, wr_cnt - base, error);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    do_reset();
    base = wr_cnt;
    drive(8'h00); drive(8'h01);
    drive(8'h11); drive(8'h22); drive(8'h33);
    @(negedge clk1);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h44;
    @(posedge clk1);
    #1;
    checks++;
    if (mem_we !== 1'b0 || words_written !== 0 || busy !== 1'b0 || rx_ready !== 1'b1 ||
        error !== 2'd0 || cpu_run !== 1'b0 || mem_addr !== 0 || mem_wdata !== 32'h0) begin
      errs++;
      $display("FAIL rst_mid: we=%b ww=%0d busy=%b rdy=%b err=%0d run=%b addr=%0d wd=%h required 0 0 0 1 0 0 0 0",
               mem_we, words_written, busy, rx_ready, error, cpu_run, mem_addr, mem_wdata);
    end
    @(negedge clk1);
    rst = 1'b0;
    rx_valid = 1'b0;
    checks++;
    if (wr_cnt != base) begin errs++; $display("FAIL rst_mid_nowrite: writes=%0d want 0", wr_cnt - base); end
    drive(8'h00); drive(8'h01);
    drive(8'h12); drive(8'h34); drive(8'h56); drive(8'h78);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 0 || mem_wdata !== 32'h12345678 || words_written !== 1) begin
      errs++;
      $display("FAIL rst_reload_word: we=%b addr=%0d data=%h ww=%0d required 1 0 12345678 1",
               mem_we, mem_addr, mem_wdata, words_written);
    end
    drive(8'h08);
    checks++;
    if (cpu_run !== 1'b1 || error !== 2'd0) begin
      errs++; $display("FAIL rst_reload_done: run=%b err=%0d required 1 0", cpu_run, error);
    end
  endtask

  initial begin
    test_reset();
    test_nominal_and_lockout();
    test_csum_error();
    test_len_error(8'h00, 8'h00);   // N = 0
    test_len_error(8'h04, 8'h01);   // N = 1025
    test_len_max();
    test_stall();
    test_reset_mid_frame();
    idle(1);
    checks++;
    if (dbl_we !== 0) begin errs++; $display("FAIL we_back_to_back: got %0d want 0", dbl_we); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
